dispatcher: RTL
===============

// Module: dispatcher
// PURPOSE
//  Opposite direction of the 3:1 weighted arbiter: takes one upstream req/ack
//  stream and distributes each item to one of three downstream consumers.
//  A 2-entry FIFO decouples upstream from downstream.
//  Target choice uses aging weights: ready consumers accumulate weight, and a
//  served consumer is cleared to 0. Sits between a single producer and
//  replicated workers.
// PARAMETERS
//  DATA_W  8  payload width
//  INC0    4  weight increment per cycle for consumer 0 while ack_out[0]=1
//  INC1    2  weight increment for consumer 1
//  INC2    1  weight increment for consumer 2
//  WGT_W   6  weight register width; saturates at 2**WGT_W-1
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       synchronous reset, active-high
//  req_in    in   1       upstream item valid
//  data_in   in   DATA_W  upstream payload
//  ack_in    out  1       upstream ready; push = req_in & ack_in
//  req_out   out  3       one-hot valid to consumer i
//  data_out  out  DATA_W  payload of FIFO head, shared by all consumers
//  ack_out   in   3       consumer i ready; fire = req_out[i] & ack_out[i]
//  level     out  2       FIFO occupancy, 0..2
// BEHAVIOUR
//  Reset: 1 cycle of rst=1 at any time clears the FIFO, all weights, state=IDLE
//   and target=0; next cycle req_out=0, ack_in=1, level=0, data_out=0.
//  FIFO: 2 entries. ack_in = (level!=2), driven from registers only.
//   Push and pop in the same cycle at level=1 leaves level at 1.
//   No push at level=2; no pop at level=0.
//  FSM:
//   IDLE  -> PICK when level!=0.
//   PICK  -> OFFER when |ack_out; target <= argmax(w). Stays in PICK if no
//            consumer is ready.
//   OFFER -> on fire: pop, then PICK if level after pop !=0, else IDLE.
//  Weights:
//   w[i] = sat(pre[i] + (ack_out[i] ? INCi : 0)), computed combinationally.
//   argmax is strict >, scanned 0..2; ties go to the lowest index.
//   Each cycle with state!=IDLE: pre[i] <= fire[i] ? 0 : w[i].
//   In IDLE, pre holds its value.
//  Outputs and handshake:
//   req_out = (state==OFFER) ? 1<<target : 0, all from registers.
//   In OFFER, target, req_out and data_out are held stable until fire, even
//   if other consumers become ready.
//   Pop occurs on the fire edge. A new target cannot be offered earlier than
//   the next PICK cycle.
//  Latency: item pushed at edge E0 into an empty FIFO with all consumers
//   ready -> PICK after E1, req_out asserted after E2, fire at E3.
//  Throughput: at most 1 item per 2 cycles (PICK + OFFER).
// TESTING
//  T1 reset: assert rst during OFFER with level=2 -> next cycle req_out=000,
//     ack_in=1, level=0; all weights read 0.
//  T2 single item: ack_out=111, push 0xA5 at E0 -> req_out=001 and
//     data_out=A5 after E2; fire at E3; level=0, state=IDLE.
//  T3 aging, all ready: ack_out=111, FIFO kept non-empty -> targets in order
//     0,1,0,2,0,1,0,2. Data order is preserved.
//  T4 partial ready: ack_out=110, back-to-back items -> targets 1,2,1,2.
//  T5 stall: in OFFER target=0 with ack_out=000 for 10 cycles, then 110 ->
//     req_out stays 001 with data_out stable; no pop. Raising ack_out[0]
//     fires to 0. ack_out=110 never redirects the item.
//  T6 full/saturation: hold ack_out=000 and push 3 items -> ack_in=0 after
//     level=2, third item held upstream. A weight held ready for more than
//     16 cycles saturates at 63 without wrapping.

Source files
------------

// File: rtl/dispatcher_if.sv
// ============================================================================
//  dispatcher_if : upstream req/ack stream plus three downstream consumer lanes
//  Revision 1.0
// ============================================================================
`default_nettype none

interface dispatcher_if #(
   parameter int DATA_W = 8
);
   logic              req_in;
   logic [DATA_W-1:0] data_in;
   logic              ack_in;
   logic [2:0]        req_out;
   logic [DATA_W-1:0] data_out;
   logic [2:0]        ack_out;
   logic [1:0]        level;

   // master: producer and consumers around the dispatcher
   modport master (
      output req_in, data_in, ack_out,
      input  ack_in, req_out, data_out, level
   );

   modport slave (
      input  req_in, data_in, ack_out,
      output ack_in, req_out, data_out, level
   );
endinterface

`default_nettype wire

// File: rtl/dispatcher.sv
// ============================================================================
//  dispatcher : 1-to-3 stream distributor with 2-entry FIFO and aging weights
//  Revision 1.0
// ============================================================================
`default_nettype none

module dispatcher #(
   parameter int DATA_W = 8,
   parameter int INC0   = 4,
   parameter int INC1   = 2,
   parameter int INC2   = 1,
   parameter int WGT_W  = 6
) (
   input  wire logic   clk,
   input  wire logic   rst,
   dispatcher_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PICK  = 2'd1,
      S_OFFER = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_target;
   logic [1:0]        w_target_nxt;

   logic [DATA_W-1:0] r_mem [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_level;
   logic [1:0]        w_level_nxt;

   logic              w_ack_in;
   logic              w_push;
   logic [2:0]        w_req_out;
   logic [2:0]        w_fire;
   logic              w_pop;

   logic [WGT_W-1:0]  r_pre [3];
   logic [WGT_W-1:0]  w_wgt [3];
   logic [1:0]        w_best;
   logic [WGT_W-1:0]  w_best_wgt;

   // ------------------------------------------------------------------
   // Handshake and FIFO bookkeeping
   // ------------------------------------------------------------------
   assign w_ack_in  = (r_level != 2'd2);
   assign w_push    = bus.req_in & w_ack_in;
   assign w_req_out = (r_state == S_OFFER) ? (3'b001 << r_target) : 3'b000;
   assign w_fire    = w_req_out & bus.ack_out;
   assign w_pop     = |w_fire;

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + 2'd1;
         2'b01:   w_level_nxt = r_level - 2'd1;
         default: w_level_nxt = r_level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_level  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_level <= w_level_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Aging weights: saturating add of the per-consumer increment
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < 3; gi++) begin : g_wgt
      localparam int C_INC = (gi == 0) ? INC0 : ((gi == 1) ? INC1 : INC2);
      logic [WGT_W:0] w_sum;
      assign w_sum      = {1'b0, r_pre[gi]} +
                          (bus.ack_out[gi] ? (WGT_W+1)'(C_INC) : {(WGT_W+1){1'b0}});
      assign w_wgt[gi]  = w_sum[WGT_W] ? {WGT_W{1'b1}} : w_sum[WGT_W-1:0];
   end

   // Strict greater-than keeps ties on the lowest index
   always_comb begin
      w_best     = 2'd0;
      w_best_wgt = w_wgt[0];
      if (w_wgt[1] > w_best_wgt) begin
         w_best     = 2'd1;
         w_best_wgt = w_wgt[1];
      end
      if (w_wgt[2] > w_best_wgt) begin
         w_best     = 2'd2;
         w_best_wgt = w_wgt[2];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            r_pre[i] <= '0;
         end
      end else if (r_state != S_IDLE) begin
         for (int i = 0; i < 3; i++) begin
            r_pre[i] <= w_fire[i] ? '0 : w_wgt[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_target <= 2'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_target <= w_target_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_target_nxt = r_target;
      case (r_state)
         S_IDLE: begin
            if (r_level != 2'd0) begin
               w_state_nxt = S_PICK;
            end
         end
         S_PICK: begin
            if (|bus.ack_out) begin
               w_target_nxt = w_best;
               w_state_nxt  = S_OFFER;
            end
         end
         S_OFFER: begin
            // Target stays latched until the offered consumer takes the item
            if (w_pop) begin
               w_state_nxt = (w_level_nxt != 2'd0) ? S_PICK : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.ack_in   = w_ack_in;
   assign bus.req_out  = w_req_out;
   assign bus.data_out = r_mem[r_rd_ptr];
   assign bus.level    = r_level;

endmodule

`default_nettype wire
